// File: rtl/shift595_pkg.sv
// Shared types and default parameters for the 74HC595 chain driver.
package shift595_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_e;

  localparam int DEF_NUM_DEV   = 2;
  localparam int DEF_HALF_CNT  = 20;
  localparam int DEF_LATCH_CNT = 2;
  localparam int DEF_PWM_BITS  = 4;

endpackage

// File: rtl/shift595_oe.sv
// OE_N dimming: free-running PWM counter compared against brightness, held off until enabled.
module shift595_oe
  import shift595_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                oe_n
);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;  // natural wrap at 2^PWM_BITS-1
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign oe_n = !(en && (cnt_q < brightness));

endmodule

// File: rtl/shift595_chain.sv
// Serial driver for NUM_DEV daisy-chained 74HC595s with a one-entry frame buffer.
// Define SHIFT595_OE_PWM_EN to add the brightness port and PWM dimming of OE_N.
module shift595_chain
  import shift595_pkg::*;
#(
  parameter int NUM_DEV   = DEF_NUM_DEV,
  parameter int HALF_CNT  = DEF_HALF_CNT,
  parameter int LATCH_CNT = DEF_LATCH_CNT,
  parameter int PWM_BITS  = DEF_PWM_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [8*NUM_DEV-1:0] s_data,
  input  logic                 lsb_first,
`ifdef SHIFT595_OE_PWM_EN
  input  logic [PWM_BITS-1:0]  brightness,
`endif
  output logic                 SCLK,
  output logic                 RCLK,
  output logic                 DIO,
  output logic                 OE_N,
  output logic                 busy,
  output logic                 done
);

  localparam int W    = 8 * NUM_DEV;
  localparam int PH_W = $clog2(2 * HALF_CNT) + 1;
  localparam int BC_W = $clog2(W) + 1;
  localparam int LC_W = $clog2(LATCH_CNT) + 1;

  state_e            state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic [W-1:0]      pend_data_q, pend_data_d;
  logic              pend_lsb_q, pend_lsb_d;
  logic [W-1:0]      sreg_q, sreg_d;
  logic [BC_W-1:0]   bit_q, bit_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [LC_W-1:0]   lc_q, lc_d;
  logic              dio_q, dio_d;
  logic              sclk_q, sclk_d;
  logic              rclk_q, rclk_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rdy_q, rdy_d;
  logic              oe_en_q, oe_en_d;
  logic [W-1:0]      norm;
  logic              accept;

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_lsb_d   = pend_lsb_q;
    sreg_d       = sreg_q;
    bit_d        = bit_q;
    ph_d         = ph_q;
    lc_d         = lc_q;
    dio_d        = dio_q;
    done_d       = 1'b0;
    oe_en_d      = oe_en_q;

    // Frames are normalised to MSB-first so the shifter always sends sreg[W-1].
    for (int i = 0; i < W; i++)
      norm[i] = pend_lsb_q ? pend_data_q[W-1-i] : pend_data_q[i];

    accept = s_valid && rdy_q;
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_data_d  = s_data;
      pend_lsb_d   = lsb_first;
    end

    case (state_q)
      IDLE: begin
        if (pend_valid_q || accept) state_d = LOAD;
      end
      LOAD: begin
        pend_valid_d = 1'b0;
        dio_d        = norm[W-1];
        sreg_d       = norm << 1;
        bit_d        = BC_W'(W - 1);
        ph_d         = '0;
        state_d      = SHIFT;
      end
      SHIFT: begin
        if (ph_q == PH_W'(2 * HALF_CNT - 1)) begin
          ph_d = '0;
          if (bit_q == '0) begin
            lc_d    = '0;
            state_d = LATCH;
          end else begin
            bit_d  = bit_q - 1'b1;
            dio_d  = sreg_q[W-1];
            sreg_d = sreg_q << 1;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      LATCH: begin
        if (lc_q == LC_W'(LATCH_CNT - 1)) begin
          done_d  = 1'b1;
          oe_en_d = 1'b1;
          state_d = IDLE;
        end else begin
          lc_d = lc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of the next-state decode, so they are glitch-free.
    sclk_d = (state_d == SHIFT) && (ph_d >= PH_W'(HALF_CNT));
    rclk_d = (state_d == LATCH);
    busy_d = (state_d != IDLE);
    rdy_d  = !pend_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_lsb_q   <= 1'b0;
      sreg_q       <= '0;
      bit_q        <= '0;
      ph_q         <= '0;
      lc_q         <= '0;
      dio_q        <= 1'b0;
      sclk_q       <= 1'b0;
      rclk_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rdy_q        <= 1'b0;
      oe_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_lsb_q   <= pend_lsb_d;
      sreg_q       <= sreg_d;
      bit_q        <= bit_d;
      ph_q         <= ph_d;
      lc_q         <= lc_d;
      dio_q        <= dio_d;
      sclk_q       <= sclk_d;
      rclk_q       <= rclk_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rdy_q        <= rdy_d;
      oe_en_q      <= oe_en_d;
    end
  end

  assign SCLK    = sclk_q;
  assign RCLK    = rclk_q;
  assign DIO     = dio_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign s_ready = rdy_q;

`ifdef SHIFT595_OE_PWM_EN
  shift595_oe #(.PWM_BITS(PWM_BITS)) u_oe (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (oe_en_q),
    .brightness (brightness),
    .oe_n       (OE_N)
  );
`else
  assign OE_N = !oe_en_q;
`endif

endmodule
